// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Purpose:
//    This is the final stage behind the BCD-to-7-segment decoders. It drives a
//    4-digit common-anode multiplexed display, lighting one digit at a time:
//    sign, hundreds, tens, then units.
//
//    New input data is held in pending registers. It moves into the display
//    registers only at a frame boundary, so a frame never shows a mix of old
//    and new digits.
//
//    Leading zeros can optionally be blanked.
//
// Ports:
//    clk        in   system clock
//    rst        in   synchronous, active-high reset
//    seg_in     in   3 x 8-bit decoded patterns
//                    [0] = hundreds, [1] = tens, [2] = units
//    sign       in   1 = value negative
//    valid      in   one-cycle strobe: capture seg_in/sign this cycle
//    blank_lz   in   1 = blank leading zeros in the hundreds and tens digits
//    an         out  anode enables, active-low
//                    an[3] = sign digit, an[0] = units
//    seg        out  segment pattern for the lit digit, active-low
//    frame_tick out  one-cycle pulse on the first cycle of each frame
//    pending    out  1 = captured data is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module seg_scan_mux #(
   parameter int unsigned REFRESH_DIV = 50000,   // cycles per digit, >= 2
   parameter logic [7:0]  ZERO_PAT    = 8'hC0,
   parameter logic [7:0]  MINUS_PAT   = 8'hBF,
   parameter logic [7:0]  BLANK_PAT   = 8'hFF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0][7:0] seg_in,
   input  logic            sign,
   input  logic            valid,
   input  logic            blank_lz,
   output logic [3:0]      an,
   output logic [7:0]      seg,
   output logic            frame_tick,
   output logic            pending
);

   localparam int unsigned     CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   // Digit index values. Index 0 is scanned first in every frame.
   localparam logic [1:0] DIG_SIGN  = 2'd0;
   localparam logic [1:0] DIG_HUND  = 2'd1;
   localparam logic [1:0] DIG_TENS  = 2'd2;
   localparam logic [1:0] DIG_UNITS = 2'd3;

   // Anode codes (active-low), one per digit index.
   localparam logic [3:0] AN_SIGN  = 4'b0111;
   localparam logic [3:0] AN_HUND  = 4'b1011;
   localparam logic [3:0] AN_TENS  = 4'b1101;
   localparam logic [3:0] AN_UNITS = 4'b1110;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   // ------------------------------------------------------------------------
   // Scan timing: prescaler and digit index
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       idx_reg;
   logic [1:0]       idx_next;
   logic             digit_end;
   logic             wrap_edge;

   assign digit_end = (cnt_reg == CNT_LAST);

   // Frame boundary: the last cycle of the units digit. The index moves 3 -> 0
   // on this edge, so display updates made here are live for the whole next
   // frame.
   assign wrap_edge = digit_end && (idx_reg == DIG_UNITS);

   always_comb begin
      cnt_next = cnt_reg + CNT_W'(1);
      idx_next = idx_reg;
      if (digit_end) begin
         cnt_next = '0;
         idx_next = idx_reg + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
         idx_reg <= DIG_SIGN;
      end else begin
         cnt_reg <= cnt_next;
         idx_reg <= idx_next;
      end
   end

   // ------------------------------------------------------------------------
   // Pending / display buffering
   //
   // A valid strobe outside the wrap edge lands in the pending registers. A
   // later strobe before commit simply overwrites them.
   //
   // A valid strobe on the wrap edge goes straight to the display registers.
   // It is the newest data, so any older pending copy is dropped.
   // ------------------------------------------------------------------------
   logic            pending_reg;
   logic            pending_next;
   logic            pend_sign_reg;
   logic            pend_sign_next;
   logic            disp_sign_reg;
   logic            disp_sign_next;
   logic [2:0][7:0] pend_pat_reg;
   logic [2:0][7:0] disp_pat_reg;

   logic            capture;   // valid outside the wrap edge
   logic            direct;    // valid on the wrap edge
   logic            commit;    // wrap edge releasing buffered data

   assign capture = valid && !wrap_edge;
   assign direct  = valid && wrap_edge;
   assign commit  = wrap_edge && !valid && pending_reg;

   always_comb begin
      pending_next   = pending_reg;
      pend_sign_next = pend_sign_reg;
      disp_sign_next = disp_sign_reg;

      if (capture) begin
         pending_next   = 1'b1;
         pend_sign_next = sign;
      end

      if (wrap_edge) begin
         pending_next = 1'b0;
      end

      if (direct) begin
         disp_sign_next = sign;
      end else if (commit) begin
         disp_sign_next = pend_sign_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg   <= 1'b0;
         pend_sign_reg <= 1'b0;
         disp_sign_reg <= 1'b0;
      end else begin
         pending_reg   <= pending_next;
         pend_sign_reg <= pend_sign_next;
         disp_sign_reg <= disp_sign_next;
      end
   end

   // Per-digit pattern buffers; every digit follows the same load rules.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         logic [7:0] pend_pat_next;
         logic [7:0] disp_pat_next;

         always_comb begin
            pend_pat_next = pend_pat_reg[gi];
            disp_pat_next = disp_pat_reg[gi];

            if (capture) begin
               pend_pat_next = seg_in[gi];
            end

            if (direct) begin
               disp_pat_next = seg_in[gi];
            end else if (commit) begin
               disp_pat_next = pend_pat_reg[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               pend_pat_reg[gi] <= 8'h00;
               disp_pat_reg[gi] <= BLANK_PAT;
            end else begin
               pend_pat_reg[gi] <= pend_pat_next;
               disp_pat_reg[gi] <= disp_pat_next;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Leading-zero blanking
   //
   // Uses the committed digits and the live blank_lz input. Tens can only
   // blank when hundreds is already blank, so a value of 0 shows just the
   // units digit.
   // ------------------------------------------------------------------------
   logic hund_blank;
   logic tens_blank;

   assign hund_blank = blank_lz   && (disp_pat_reg[0] == ZERO_PAT);
   assign tens_blank = hund_blank && (disp_pat_reg[1] == ZERO_PAT);

   // ------------------------------------------------------------------------
   // Output registers
   //
   // an and seg are decoded from the same index, on the same edge, so the
   // anode and segment lines never disagree for a cycle.
   // ------------------------------------------------------------------------
   logic [3:0] an_reg;
   logic [3:0] an_next;
   logic [7:0] seg_reg;
   logic [7:0] seg_next;
   logic       frame_tick_reg;
   logic       frame_tick_next;

   always_comb begin
      an_next  = AN_OFF;
      seg_next = BLANK_PAT;

      case (idx_reg)
         DIG_SIGN: begin
            an_next  = AN_SIGN;
            seg_next = disp_sign_reg ? MINUS_PAT : BLANK_PAT;
         end
         DIG_HUND: begin
            an_next  = AN_HUND;
            seg_next = hund_blank ? BLANK_PAT : disp_pat_reg[0];
         end
         DIG_TENS: begin
            an_next  = AN_TENS;
            seg_next = tens_blank ? BLANK_PAT : disp_pat_reg[1];
         end
         DIG_UNITS: begin
            an_next  = AN_UNITS;
            seg_next = disp_pat_reg[2];
         end
         default: begin
            an_next  = AN_OFF;
            seg_next = BLANK_PAT;
         end
      endcase

      // The first cycle of the sign digit is the first cycle of the frame.
      frame_tick_next = (idx_reg == DIG_SIGN) && (cnt_reg == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_reg         <= AN_OFF;
         seg_reg        <= BLANK_PAT;
         frame_tick_reg <= 1'b0;
      end else begin
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   assign an         = an_reg;
   assign seg        = seg_reg;
   assign frame_tick = frame_tick_reg;
   assign pending    = pending_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Self-checking bench for seg_scan_mux, built with REFRESH_DIV = 4.
//
// A reference model tracks the scan position since the last reset as a plain
// cycle count. From that count it derives:
//    - which digit is lit,
//    - where frames start,
//    - when the wrap edge falls.
// It also keeps copies of the committed and the pending values.
//
// Stimulus is the directed test-plan scenarios first, then a randomized run
// with random strobes, patterns, blanking changes and occasional resets.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

   localparam int unsigned DIV   = 4;
   localparam int unsigned FRAME = 4 * DIV;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0][7:0] seg_in;
   logic            sign;
   logic            valid;
   logic            blank_lz;
   logic [3:0]      an;
   logic [7:0]      seg;
   logic            frame_tick;
   logic            pending;

   seg_scan_mux #(
      .REFRESH_DIV (DIV),
      .ZERO_PAT    (8'hC0),
      .MINUS_PAT   (8'hBF),
      .BLANK_PAT   (8'hFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .sign       (sign),
      .valid      (valid),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Compares one observed value against its expected value.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int unsigned     m_pos = 0;          // non-reset edges since reset release
   logic [7:0]      m_disp [3] = '{8'hFF, 8'hFF, 8'hFF};
   logic            m_dsign = 1'b0;
   logic [7:0]      m_pend [3] = '{8'h00, 8'h00, 8'h00};
   logic            m_psign = 1'b0;
   logic            m_pending = 1'b0;

   logic [3:0]      exp_an = 4'hF;
   logic [7:0]      exp_seg = 8'hFF;
   logic            exp_tick = 1'b0;
   logic            exp_pending = 1'b0;

   // Called once per rising edge with the inputs the DUT just sampled.
   task automatic model_edge();
      int  digit;
      bit  hb;
      bit  tb_blank;

      if (rst) begin
         m_pos       = 0;
         m_disp      = '{8'hFF, 8'hFF, 8'hFF};
         m_dsign     = 1'b0;
         m_pending   = 1'b0;
         exp_an      = 4'hF;
         exp_seg     = 8'hFF;
         exp_tick    = 1'b0;
         exp_pending = 1'b0;
         return;
      end

      // The lit digit comes from the scan position; its content comes from
      // the display values as they stood before this edge.
      digit    = (m_pos / DIV) % 4;
      exp_tick = ((m_pos % FRAME) == 0);
      hb       = blank_lz && (m_disp[0] == 8'hC0);
      tb_blank = hb && (m_disp[1] == 8'hC0);

      case (digit)
         0: begin
            exp_an  = 4'b0111;
            exp_seg = m_dsign ? 8'hBF : 8'hFF;
         end
         1: begin
            exp_an  = 4'b1011;
            exp_seg = hb ? 8'hFF : m_disp[0];
         end
         2: begin
            exp_an  = 4'b1101;
            exp_seg = tb_blank ? 8'hFF : m_disp[1];
         end
         default: begin
            exp_an  = 4'b1110;
            exp_seg = m_disp[2];
         end
      endcase

      // The last cycle of each frame is the frame boundary.
      if ((m_pos % FRAME) == FRAME - 1) begin
         if (valid) begin
            for (int i = 0; i < 3; i++) m_disp[i] = seg_in[i];
            m_dsign = sign;
         end else if (m_pending) begin
            m_disp  = m_pend;
            m_dsign = m_psign;
         end
         m_pending = 1'b0;
      end else if (valid) begin
         for (int i = 0; i < 3; i++) m_pend[i] = seg_in[i];
         m_psign   = sign;
         m_pending = 1'b1;
      end

      exp_pending = m_pending;
      m_pos++;
   endtask

   // One clock: model on the rising edge, check on the falling edge.
   task automatic step();
      @(posedge clk);
      if (valid)
         $display("txn valid pos=%0d rst=%0b h=%02h t=%02h u=%02h sign=%0b blank_lz=%0b",
                  m_pos % FRAME, rst, seg_in[0], seg_in[1], seg_in[2], sign, blank_lz);
      model_edge();
      @(negedge clk);
      chk("an", {4'h0, an}, {4'h0, exp_an});
      chk("seg", seg, exp_seg);
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, exp_tick});
      chk("pending", {7'h0, pending}, {7'h0, exp_pending});
   endtask

   // Step until the next edge falls at frame position 'target'.
   task automatic run_to(input int unsigned target);
      for (int i = 0; i < FRAME + 1; i++) begin
         if ((m_pos % FRAME) == target) return;
         step();
      end
      chk("run_to_timeout", 8'd1, 8'd0);
   endtask

   // Drive a one-cycle valid strobe with the given digits.
   task automatic strobe(input logic [7:0] h, input logic [7:0] t,
                         input logic [7:0] u, input logic s);
      seg_in[0] = h;
      seg_in[1] = t;
      seg_in[2] = u;
      sign      = s;
      valid     = 1'b1;
      step();
      valid     = 1'b0;
   endtask

   logic [7:0] pats [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   initial begin
      rst      = 1'b1;
      valid    = 1'b0;
      sign     = 1'b0;
      blank_lz = 1'b0;
      seg_in   = '0;

      // Reset, then free-running scan with no data.
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 2 * FRAME + 3; i++) step();

      // Mid-frame capture, committed at the next boundary.
      run_to(5);
      strobe(8'hB0, 8'hA4, 8'hF9, 1'b1);
      chk("pending_after_capture", {7'h0, pending}, 8'd1);
      for (int i = 0; i < 2 * FRAME; i++) step();

      // Leading-zero blanking: 000, then 010.
      blank_lz = 1'b1;
      run_to(3);
      strobe(8'hC0, 8'hC0, 8'hC0, 1'b0);
      for (int i = 0; i < 2 * FRAME; i++) step();
      run_to(7);
      strobe(8'hC0, 8'hF9, 8'hC0, 1'b0);
      for (int i = 0; i < 2 * FRAME; i++) step();
      blank_lz = 1'b0;

      // Two captures in one frame: the last one wins.
      run_to(2);
      strobe(8'hB0, 8'hB0, 8'hF9, 1'b0);
      step();
      strobe(8'hB0, 8'hB0, 8'hA4, 1'b0);
      for (int i = 0; i < 2 * FRAME; i++) step();

      // Strobe exactly on the wrap edge, with older data still pending.
      run_to(4);
      strobe(8'h99, 8'h99, 8'h99, 1'b0);
      run_to(FRAME - 1);
      strobe(8'h92, 8'h82, 8'hF8, 1'b1);
      chk("pending_after_direct", {7'h0, pending}, 8'd0);
      for (int i = 0; i < FRAME + 2; i++) step();

      // Reset while data is pending, mid-frame.
      run_to(6);
      strobe(8'h80, 8'h90, 8'hF9, 1'b0);
      rst = 1'b1;
      step();
      chk("rst_an", {4'h0, an}, 8'h0F);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_pending", {7'h0, pending}, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) step();

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         valid = ($urandom_range(0, 7) == 0);
         if (valid) begin
            for (int d = 0; d < 3; d++) seg_in[d] = pats[$urandom_range(0, 9)];
            sign = $urandom_range(0, 1) == 1;
         end
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      valid = 1'b0;
      rst   = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Output stage directly downstream of the BCD-to-7-segment decoders.
- Takes the three decoded digit patterns (hundreds, tens, units) and the sign bit, and drives a 4-digit common-anode multiplexed display one digit at a time.
- Input updates are buffered and committed only at frame boundaries, so the display never tears.
- Optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit; minimum 2.
- ZERO_PAT, 8'hC0: segment pattern the decoder emits for digit 0; used for leading-zero detection.
- MINUS_PAT, 8'hBF: pattern shown on the sign digit when negative (segment g only, active-low).
- BLANK_PAT, 8'hFF: all segments off (active-low).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  8 x [2:0]  decoded patterns; [0]=hundreds, [1]=tens, [2]=units
- sign  input  1  1 = value negative
- valid  input  1  one-cycle strobe; seg_in/sign are valid and must be captured
- blank_lz  input  1  1 = blank leading zeros in the hundreds and tens digits
- an  output  4  anode enables, active-low; an[3]=sign digit, an[0]=units
- seg  output  8  segment pattern for the lit digit, active-low
- frame_tick  output  1  one-cycle pulse on the first cycle of each frame
- pending  output  1  1 = captured data is waiting for the next frame boundary

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset values:
  - an=4'hF, seg=BLANK_PAT, frame_tick=0, pending=0.
  - Prescaler=0, digit index=0.
  - Display registers: all digits BLANK_PAT, sign 0.
  - Pending registers cleared.
- Reset asserted mid-frame or with pending data: everything returns to reset values; pending data is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the 2-bit digit index advances 0→1→2→3→0.
  - The index 3→0 advance is the frame boundary ("wrap edge").
- Capture:
  - A valid cycle that is not a wrap edge loads seg_in/sign into the pending registers and sets pending=1.
  - A later valid before commit overwrites the pending registers (last value wins).
- Commit: at a wrap edge with pending=1, the display registers load the pending registers and pending clears.
- Valid coinciding with the wrap edge: seg_in/sign load directly into the display registers. Any older pending data is dropped and pending clears.
- Digit mapping (index → anode, pattern):
  - 0 → an=4'b0111: MINUS_PAT if display sign=1, else BLANK_PAT.
  - 1 → an=4'b1011: hundreds, or BLANK_PAT if blanked.
  - 2 → an=4'b1101: tens, or BLANK_PAT if blanked.
  - 3 → an=4'b1110: units, never blanked.
- Leading-zero blanking, evaluated from the display registers and the live blank_lz input:
  - Hundreds blanked when blank_lz=1 and hundreds==ZERO_PAT.
  - Tens blanked when hundreds is blanked and tens==ZERO_PAT.
  - Value 0 therefore shows only the units digit.
- Output timing:
  - an and seg are registered and change one cycle after the index changes. Each digit is lit for exactly REFRESH_DIV cycles.
  - An index change takes effect in the same cycle for both an and seg; no one-cycle ghosting between them.
- frame_tick: registered; high for one cycle, in the first cycle where an=4'b0111 of each frame.
- First frame after reset: index 0 lit from cycle 1 after rst deasserts, showing blank until the first commit.

Test Plan (REFRESH_DIV=4):
- Release reset, no valid → an cycles 0111,1011,1101,1110 every 4 clocks; seg=FF throughout; frame_tick every 16 clocks.
- valid with seg_in={units 8'hF9, tens 8'hA4, hundreds 8'hB0}, sign=1, mid-frame → pending=1 until the wrap edge. Next frame shows BF, B0, A4, F9 on an 0111/1011/1101/1110; pending=0.
- blank_lz=1, committed hundreds=C0, tens=C0, units=C0 → seg=FF on sign, hundreds and tens; C0 on units. With hundreds=C0, tens=F9: hundreds blanked, tens shows F9.
- Two valids in one frame (first units F9, then units A4) → only A4 ever displayed.
- valid exactly on the wrap edge → new data visible on sign digit of the immediately following frame; pending stays 0.
- Assert rst for 1 cycle while pending=1 mid-frame → next cycle an=F, seg=FF, pending=0; scanning restarts at index 0 with blank display.
